goto_rep_monitor: RTL
=====================

# goto_rep_monitor

Synthesizable run-time checker for the goto-repetition property `a |-> b[->REP_N]`, with an optional trailing `##1 c`. It sits beside the datapath as a hardware twin of the simulation assertion, so the same check runs on emulation and FPGA builds. It sequences one attempt at a time and reports pass/fail pulses, a failure cause and saturating event counters.

## Interface
- REP_N, 3, number of (non-consecutive) `b` hits required; legal range 1..255
- TIMEOUT, 0, max cycles an attempt may stay open after the trigger cycle; 0 = unbounded (weak property)
- CNT_W, 16, width of pass/fail/drop counters

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  sampling clock; all inputs sampled on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  monitor enable; when 0, no new attempt starts (open attempt continues)
- a  in  1  antecedent/trigger
- b  in  1  repetition event
- c  in  1  trailing event (used only with macro)
- busy  out  1  attempt open
- hit_cnt  out  8  `b` hits counted in the current attempt
- pass  out  1  one-cycle pulse, attempt succeeded
- fail  out  1  one-cycle pulse, attempt failed
- fail_code  out  2  cause of last fail: 00 none, 01 timeout, 10 missing c; holds until the next fail
- drop  out  1  one-cycle pulse, trigger ignored because busy
- pass_cnt  out  CNT_W  saturating count of passes
- fail_cnt  out  CNT_W  saturating count of fails
- drop_cnt  out  CNT_W  saturating count of drops

## Operation
- FSM states: IDLE, COUNT, WAIT_C (WAIT_C exists only with macro).
- IDLE: on `en && a` -> attempt opens. Overlapping implication: `b` in the trigger cycle counts as hit 1. If hits reach REP_N in the trigger cycle -> complete (below). Otherwise -> COUNT with hit_cnt = hits so far.
- COUNT: each cycle with `b` increments hit_cnt. Cycles without `b` are allowed, unbounded unless TIMEOUT > 0. On the REP_N-th hit -> complete.
- Complete without macro: pass pulse -> IDLE. With macro: -> WAIT_C; next cycle `c`=1 -> pass, else fail with code 10; either way -> IDLE.
- Timeout: an elapsed counter starts at 0 in the trigger cycle and increments each following open cycle. When it reaches TIMEOUT without completion, fail with code 01 -> IDLE. A hit landing in the timeout cycle wins, i.e. it is pass/complete.
- Single-thread: `a` seen while busy (COUNT, WAIT_C, or the cycle a completion is decided) -> drop pulse; no new attempt.
- Counters saturate at all-ones; no wrap.
- hit_cnt clears to 0 on return to IDLE.

## Timing
- All outputs are registered. pass/fail/drop assert on the clock edge after the deciding sample and last exactly one cycle.
- Latency trigger->pass, no macro: cycle of the REP_N-th `b` + 1. With macro: that cycle + 2.
- busy rises the edge after the trigger; it falls in the same edge that pulses pass/fail.
- Back-to-back: earliest next trigger is the sample cycle in which pass/fail is visible.
- Reset (rst_n low, any state, mid-attempt included): state IDLE; busy, pass, fail, drop = 0; hit_cnt = 0; fail_code = 00; all counters = 0. The open attempt is discarded with no pulse.
- Deassertion of en mid-attempt has no effect on that attempt.

## Configuration
- GOTO_REP_TRAIL_C_EN defined: property is `a |-> b[->REP_N] ##1 c`. WAIT_C state, `c` input and fail_code 10 are active.
- Undefined: property is `a |-> b[->REP_N]`. `c` is ignored, WAIT_C is not built, and fail_code 10 never occurs.

## Test plan
- REP_N=3, no macro: a@cycle2; b@3,4,6 -> pass pulse at cycle 7, pass_cnt=1, busy 3..6.
- REP_N=3, macro: a@8; b@9,11,13; c@14 -> pass at 15. Repeat with c=0 @14 -> fail at 15, fail_code=10.
- REP_N=2, TIMEOUT=4: a@0; b@2 only -> fail at cycle 5, fail_code=01, hit_cnt=0 after. Variant with b@4 -> pass at 5.
- REP_N=1: a and b both @5 -> pass at 6, busy never asserted. REP_N=3: a and b @5, b@6,7 -> pass at 8.
- Overlap: a@2, a@4, b@3,5,7 (REP_N=3) -> one pass at 8, drop at 5, drop_cnt=1.
- Reset mid-attempt: a@2, b@3, rst_n low @4 -> no pass/fail, all outputs 0. After release, a fresh attempt passes normally. Counter saturation: force 2^CNT_W passes (CNT_W=4) -> pass_cnt holds 15.

Source files
------------

// File: rtl/goto_rep_monitor.sv
// Hardware checker for a |-> b[->REP_N] (optionally ##1 c), one attempt at a time.
// Define GOTO_REP_TRAIL_C_EN to add the trailing ##1 c step (WAIT_C state).
module goto_rep_monitor #(
  parameter int REP_N   = 3,
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             busy,
  output logic [7:0]       hit_cnt,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic             drop,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

`ifdef GOTO_REP_TRAIL_C_EN
  typedef enum logic [1:0] {
    IDLE, COUNT, WAIT_C
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE, COUNT
  } state_e;
  logic unused_c;
  assign unused_c = c;
`endif

  localparam logic [7:0]  REP8 = 8'(REP_N);
  localparam logic [31:0] TO32 = 32'(TIMEOUT);
  localparam bit          HAS_TO = (TIMEOUT > 0);

  state_e           state_q, state_d;
  logic [7:0]       hit_q, hit_d;
  logic [31:0]      el_q, el_d;
  logic             busy_q, busy_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             drop_q, drop_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] pcnt_q, fcnt_q, dcnt_q;

  logic [7:0]  hits_now;
  logic [31:0] el_now;
  logic        done;
  logic        complete;

  // hit_q is 0 in IDLE, so one adder serves the trigger cycle too
  assign hits_now = hit_q + {7'd0, b};
  assign done     = b && (hits_now == REP8);
  assign el_now   = el_q + 32'd1;

  always_comb begin
    state_d  = state_q;
    hit_d    = hit_q;
    el_d     = el_q;
    pass_d   = 1'b0;
    fail_d   = 1'b0;
    drop_d   = 1'b0;
    code_d   = code_q;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && a) begin
          el_d = 32'd0;
          if (done) begin
            complete = 1'b1;
          end else begin
            state_d = COUNT;
            hit_d   = hits_now;
          end
        end
      end
      COUNT: begin
        drop_d = a;
        el_d   = el_now;
        hit_d  = hits_now;
        if (done) begin
          complete = 1'b1;
        end else if (HAS_TO && el_now >= TO32) begin
          fail_d  = 1'b1;
          code_d  = 2'b01;
          state_d = IDLE;
          hit_d   = 8'd0;
        end
      end
`ifdef GOTO_REP_TRAIL_C_EN
      WAIT_C: begin
        drop_d  = a;
        state_d = IDLE;
        hit_d   = 8'd0;
        if (c) begin
          pass_d = 1'b1;
        end else begin
          fail_d = 1'b1;
          code_d = 2'b10;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        hit_d   = 8'd0;
      end
    endcase
    if (complete) begin
`ifdef GOTO_REP_TRAIL_C_EN
      state_d = WAIT_C;
      hit_d   = REP8;
`else
      state_d = IDLE;
      hit_d   = 8'd0;
      pass_d  = 1'b1;
`endif
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hit_q   <= 8'd0;
      el_q    <= 32'd0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      drop_q  <= 1'b0;
      code_q  <= 2'b00;
      pcnt_q  <= '0;
      fcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      el_q    <= el_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      drop_q  <= drop_d;
      code_q  <= code_d;
      if (pass_d && !(&pcnt_q)) pcnt_q <= pcnt_q + 1'b1;
      if (fail_d && !(&fcnt_q)) fcnt_q <= fcnt_q + 1'b1;
      if (drop_d && !(&dcnt_q)) dcnt_q <= dcnt_q + 1'b1;
    end
  end

  assign busy      = busy_q;
  assign hit_cnt   = hit_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_code = code_q;
  assign drop      = drop_q;
  assign pass_cnt  = pcnt_q;
  assign fail_cnt  = fcnt_q;
  assign drop_cnt  = dcnt_q;

endmodule
